// File: rtl/temp_uart_pkg.sv
// -----------------------------------------------------------------------------
// temp_uart_pkg
//   Shared definitions for the temperature UART link. The TX-side formatter and
//   the RX-side parser (uart_recv_temp) use the same ASCII constants, so both
//   ends of the link always agree on the frame format "DD.D<LF>".
//
//   Contents:
//     ASC_*       ASCII byte constants used by the frame format
//     rx_state_e  parser FSM state encoding
// -----------------------------------------------------------------------------
package temp_uart_pkg;

  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_9   = 8'h39;
  localparam logic [7:0] ASC_DOT = 8'h2E;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;

  // ST_D_TEN names the "expecting tens digit" phase of a frame. The parser folds
  // that phase into ST_IDLE: a digit received while idle is the tens digit. The
  // encoding is kept so state values stay stable for anything decoding them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_TEN  = 3'd1,
    ST_D_UNIT = 3'd2,
    ST_DOT    = 3'd3,
    ST_D_DEC  = 3'd4,
    ST_EOL    = 3'd5,
    ST_FLUSH  = 3'd6
  } rx_state_e;

endpackage : temp_uart_pkg

// File: rtl/uart_gap_timer.sv
// -----------------------------------------------------------------------------
// uart_gap_timer
//   Inter-byte gap watchdog. Counts clock cycles while enabled; the count is
//   held at zero whenever the timer is disabled or cleared. timeout_o is a
//   combinational pulse in the cycle the count sits at CYCLES-1 while still
//   enabled and not being cleared, so a clear arriving in that same cycle
//   always wins over the timeout.
//
//   Ports:
//     clk_i      in   1  clock
//     rst_ni     in   1  asynchronous reset, active-low
//     clr_i      in   1  restart the count (a byte was received)
//     en_i       in   1  count enable (a frame is in progress)
//     timeout_o  out  1  gap limit reached
// -----------------------------------------------------------------------------
module uart_gap_timer #(
  parameter int unsigned CYCLES = 120000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || !en_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      // Saturate: the owner leaves the timed state right after the timeout,
      // which disables and clears the count anyway.
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_o = en_i && !clr_i && (cnt_q == LAST);

endmodule : uart_gap_timer

// File: rtl/uart_recv_temp.sv
// -----------------------------------------------------------------------------
// uart_recv_temp
//   Parses ASCII temperature-threshold frames "DD.D<LF>" (e.g. "25.5\n")
//   arriving byte by byte from uart_rx, and holds the last good threshold as
//   three BCD digits plus a binary value in tenths of a degree. Malformed or
//   stalled frames are dropped, flagged on frame_err, and leave the held
//   threshold untouched.
//
//   Input handshake: uart_rx_done is a one-cycle qualifier for uart_rx_data.
//   There is no back-pressure; every strobed byte, including strobes on
//   consecutive cycles, is consumed in the cycle it is presented.
//
//   Ports:
//     sys_clk       in   1   system clock
//     sys_rst_n     in   1   asynchronous reset, active-low
//     uart_rx_done  in   1   byte strobe
//     uart_rx_data  in   8   received byte
//     thr_ten       out  4   BCD tens digit of threshold
//     thr_unit      out  4   BCD units digit
//     thr_dec       out  4   BCD tenths digit
//     thr_tenths    out  10  binary threshold in tenths (0..999)
//     thr_update    out  1   pulse: new threshold committed
//     frame_err     out  1   pulse: frame aborted (bad byte or gap timeout)
//     busy          out  1   a frame is partially received (state != IDLE)
// -----------------------------------------------------------------------------
module uart_recv_temp
  import temp_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned GAP_MS     = 10,
  parameter int unsigned DEF_TENTHS = 300
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  output logic [3:0] thr_ten,
  output logic [3:0] thr_unit,
  output logic [3:0] thr_dec,
  output logic [9:0] thr_tenths,
  output logic       thr_update,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned GAP_CYCLES = CLK_FREQ / 1000 * GAP_MS;

  localparam logic [3:0] DEF_TEN  = 4'(DEF_TENTHS / 100);
  localparam logic [3:0] DEF_UNIT = 4'((DEF_TENTHS / 10) % 10);
  localparam logic [3:0] DEF_DEC  = 4'(DEF_TENTHS % 10);
  localparam logic [9:0] DEF_VAL  = 10'(DEF_TENTHS);

  // ten*100 + unit*10 + dec using shifts and adds only; the largest result
  // is 999, so 10 bits never overflow.
  function automatic logic [9:0] tenths_of(input logic [3:0] ten,
                                           input logic [3:0] unit,
                                           input logic [3:0] dec);
    logic [9:0] t;
    logic [9:0] u;
    logic [9:0] d;
    t = {6'd0, ten};
    u = {6'd0, unit};
    d = {6'd0, dec};
    return (t << 6) + (t << 5) + (t << 2) + (u << 3) + (u << 1) + d;
  endfunction

  rx_state_e  state_q;
  logic [3:0] ten_sh_q;
  logic [3:0] unit_sh_q;
  logic [3:0] dec_sh_q;
  logic [3:0] thr_ten_q;
  logic [3:0] thr_unit_q;
  logic [3:0] thr_dec_q;
  logic [9:0] thr_tenths_q;
  logic [9:0] thr_tenths_d;
  logic       thr_update_q;
  logic       frame_err_q;

  logic       rx_is_digit;
  logic [3:0] rx_digit;
  logic       gap_en;
  logic       gap_timeout;

  // ASCII '0'..'9' are 8'h30..8'h39, so the low nibble is the digit value.
  assign rx_is_digit = (uart_rx_data >= ASC_0) && (uart_rx_data <= ASC_9);
  assign rx_digit    = uart_rx_data[3:0];

  // The binary value is built from the shadows, which are all valid by the
  // time the LF arrives in ST_EOL.
  always_comb begin
    thr_tenths_d = tenths_of(ten_sh_q, unit_sh_q, dec_sh_q);
  end

  // Timing only applies inside a frame; ST_FLUSH waits for LF indefinitely.
  assign gap_en = (state_q != ST_IDLE) && (state_q != ST_FLUSH);

  uart_gap_timer #(
    .CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .clr_i     (uart_rx_done),
    .en_i      (gap_en),
    .timeout_o (gap_timeout)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      ten_sh_q     <= '0;
      unit_sh_q    <= '0;
      dec_sh_q     <= '0;
      thr_ten_q    <= DEF_TEN;
      thr_unit_q   <= DEF_UNIT;
      thr_dec_q    <= DEF_DEC;
      thr_tenths_q <= DEF_VAL;
      thr_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      thr_update_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (uart_rx_done) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_is_digit) begin
              ten_sh_q <= rx_digit;
              state_q  <= ST_D_UNIT;
            end else if ((uart_rx_data != ASC_CR) && (uart_rx_data != ASC_LF)) begin
              state_q     <= ST_FLUSH;
              frame_err_q <= 1'b1;
            end
          end

          ST_D_UNIT: begin
            if (rx_is_digit) begin
              unit_sh_q <= rx_digit;
              state_q   <= ST_DOT;
            end else begin
              state_q     <= ST_FLUSH;
              frame_err_q <= 1'b1;
            end
          end

          ST_DOT: begin
            if (uart_rx_data == ASC_DOT) begin
              state_q <= ST_D_DEC;
            end else begin
              state_q     <= ST_FLUSH;
              frame_err_q <= 1'b1;
            end
          end

          ST_D_DEC: begin
            if (rx_is_digit) begin
              dec_sh_q <= rx_digit;
              state_q  <= ST_EOL;
            end else begin
              state_q     <= ST_FLUSH;
              frame_err_q <= 1'b1;
            end
          end

          ST_EOL: begin
            if (uart_rx_data == ASC_LF) begin
              // All four threshold outputs move on the same edge, so a
              // consumer never sees a mix of old and new digits.
              thr_ten_q    <= ten_sh_q;
              thr_unit_q   <= unit_sh_q;
              thr_dec_q    <= dec_sh_q;
              thr_tenths_q <= thr_tenths_d;
              thr_update_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else if (uart_rx_data != ASC_CR) begin
              state_q     <= ST_FLUSH;
              frame_err_q <= 1'b1;
            end
          end

          ST_FLUSH: begin
            // Already flagged on entry; stay silent until the frame ends.
            if (uart_rx_data == ASC_LF) begin
              state_q <= ST_IDLE;
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end else if (gap_timeout) begin
        // A stalled frame is simply abandoned; the next byte starts afresh.
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
      end
    end
  end

  assign thr_ten    = thr_ten_q;
  assign thr_unit   = thr_unit_q;
  assign thr_dec    = thr_dec_q;
  assign thr_tenths = thr_tenths_q;
  assign thr_update = thr_update_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule : uart_recv_temp

// File: tb/tb_uart_recv_temp.sv
module tb_uart_recv_temp;

  // 1 MHz and 1 ms gives a 1000-cycle gap limit.
  localparam int CLK_FREQ = 1_000_000;
  localparam int GAP_MS   = 1;
  localparam int LIMIT    = 1000;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] thr_ten;
  logic [3:0] thr_unit;
  logic [3:0] thr_dec;
  logic [9:0] thr_tenths;
  logic       thr_update;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_recv_temp #(
    .CLK_FREQ   (CLK_FREQ),
    .GAP_MS     (GAP_MS),
    .DEF_TENTHS (300)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .uart_rx_done (rx_done),
    .uart_rx_data (rx_data),
    .thr_ten      (thr_ten),
    .thr_unit     (thr_unit),
    .thr_dec      (thr_dec),
    .thr_tenths   (thr_tenths),
    .thr_update   (thr_update),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  // ---------------------------------------------------------------- scoreboard
  // Entry: {is_err, tenths[9:0], ten, unit, dec}
  logic [22:0] exp_q[$];
  int          exp_idx_q[$];   // strobe the pulse follows
  int          exp_off_q[$];   // extra cycles after that strobe's edge

  int strobe_edge[0:255];
  int n_strobes = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [22:0] mk(input bit err, input int t, input int u, input int d);
    logic [9:0] v;
    v = 10'(t * 100 + u * 10 + d);
    return {err, v, 4'(t), 4'(u), 4'(d)};
  endfunction

  task automatic expect_pulse(input bit err, input int t, input int u, input int d,
                              input int idx, input int off);
    exp_q.push_back(mk(err, t, u, d));
    exp_idx_q.push_back(idx);
    exp_off_q.push_back(off);
  endtask

  // ---------------------------------------------------------------- monitor
  logic [22:0] mon_exp;
  logic [22:0] mon_got;
  int          mon_idx;
  int          mon_off;

  always @(negedge clk) begin
    if (rst_n) begin
      if (thr_update && frame_err) begin
        check("pulse_exclusive", 32'd1, 32'd0);
      end
      if (thr_update || frame_err) begin
        mon_got = {frame_err, thr_tenths, thr_ten, thr_unit, thr_dec};
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got update=%0b err=%0b tenths=%0d expected no pulse (cycle %0d)",
                   thr_update, frame_err, thr_tenths, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_idx = exp_idx_q.pop_front();
          mon_off = exp_off_q.pop_front();
          check("pulse_value", 32'(mon_got), 32'(mon_exp));
          check("pulse_cycle", 32'(cyc), 32'(strobe_edge[mon_idx] + mon_off));
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic send_byte(input logic [7:0] b, input int idle);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    if (n_strobes < 256) strobe_edge[n_strobes] = cyc;
    n_strobes++;
    rx_done = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int idle);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], idle);
  endtask

  task automatic check_thr(input string name, input int t, input int u, input int d);
    check({name, "_ten"},    32'(thr_ten),    32'(t));
    check({name, "_unit"},   32'(thr_unit),   32'(u));
    check({name, "_dec"},    32'(thr_dec),    32'(d));
    check({name, "_tenths"}, 32'(thr_tenths), 32'(t * 100 + u * 10 + d));
  endtask

  // ---------------------------------------------------------------- stimulus
  int base;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_thr("reset", 3, 0, 0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_update", 32'(thr_update), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);

    // Plain frame with idle gaps between bytes.
    base = n_strobes;
    expect_pulse(0, 2, 5, 5, base + 4, 0);
    send_str("25.5\n", 2);
    repeat (3) @(negedge clk);
    check("busy_after_frame", 32'(busy), 32'd0);

    // Back-to-back strobes, CR before LF ignored.
    base = n_strobes;
    expect_pulse(0, 9, 9, 9, base + 5, 0);
    send_str("99.9\r\n", 0);
    base = n_strobes;
    expect_pulse(0, 0, 0, 0, base + 4, 0);
    send_str("00.0\n", 0);

    // CR while idle is ignored.
    base = n_strobes;
    expect_pulse(0, 5, 5, 0, base + 5, 0);
    send_str("\r55.0\n", 1);

    // Bad digit: one error on 'a', further junk silently flushed until LF.
    base = n_strobes;
    expect_pulse(1, 5, 5, 0, base + 1, 0);
    send_str("2a", 1);
    check("busy_in_flush", 32'(busy), 32'd1);
    send_str(".5x\n", 1);
    repeat (2) @(negedge clk);
    check("busy_after_flush", 32'(busy), 32'd0);
    check_thr("kept_after_err", 5, 5, 0);

    base = n_strobes;
    expect_pulse(0, 1, 2, 3, base + 4, 0);
    send_str("12.3\n", 1);

    // Stalled frame: timeout error LIMIT cycles after the last strobe edge.
    base = n_strobes;
    expect_pulse(1, 1, 2, 3, base, LIMIT);
    send_byte("3", 0);
    check("busy_mid_frame", 32'(busy), 32'd1);
    repeat (LIMIT + 20) @(negedge clk);
    check("busy_after_timeout", 32'(busy), 32'd0);

    base = n_strobes;
    expect_pulse(0, 4, 1, 0, base + 4, 0);
    send_str("41.0\n", 1);
    repeat (2) @(negedge clk);
    check_thr("before_reset", 4, 1, 0);

    // Reset mid-frame reverts threshold to default and returns to IDLE.
    send_str("18.", 1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_thr("in_reset", 3, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_thr("after_reset", 3, 0, 0);
    check("busy_after_reset", 32'(busy), 32'd0);
    send_str("\n", 1);
    repeat (5) @(negedge clk);
    check("busy_after_lone_lf", 32'(busy), 32'd0);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_recv_temp
